mask_unit: RTL and testbench

MASK_UNIT -- requirements
Module: mask_unit

---
 rtl/mask_unit.sv | 111 +++++++++++
 tb/tb_mask_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mask_unit.sv
// mask_unit: bitwise mask operations on an operand stream.
// Results queue in a small FIFO ahead of the consumer.
module mask_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mask_we,
    input  logic [WIDTH-1:0]           mask_in,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_zero,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_ANDN = 2'b11;

    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    // Flow control depends only on registered count, never on
    // out_ready or in_valid, so a full buffer frees a slot a cycle
    // after the pop.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is not reset, so the head entry is gated by out_valid.
    assign out      = out_valid ? mem[head] : '0;
    assign out_zero = out_valid && (out == '0);

    // Operation on the operand using the mask as it stood before
    // this edge; a same-cycle mask write lands afterwards.
    always_comb begin
        result = '0;
        unique case (mode)
            MODE_AND:  result = in & mask_q;
            MODE_OR:   result = in | mask_q;
            MODE_XOR:  result = in ^ mask_q;
            MODE_ANDN: result = in & ~mask_q;
            default:   result = '0;
        endcase
    end

    // Mask register, all ones out of reset so the unit passes data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '1;
        end else if (mask_we) begin
            mask_q <= mask_in;
        end
    end

    // Result storage written at the tail on every accept.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= result;
        end
    end

    // Tail pointer; power-of-two depth makes the wrap implicit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tail <= '0;
        end else if (push) begin
            tail <= tail + PW'(1);
        end
    end

    // Head pointer advances on each pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
        end else if (pop) begin
            head <= head + PW'(1);
        end
    end

    // Occupancy; push and pop together cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mask_unit.sv
// tb_mask_unit: scoreboard bench for mask_unit.
// Expected results queue at accept and are matched at the head.
module tb_mask_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mask_we = 1'b0;
    logic [WIDTH-1:0] mask_in = '0;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_zero;
    logic [CW-1:0]    count;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] m_mask = '1;

    always #5 clk = ~clk;

    mask_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .mask_we(mask_we),
        .mask_in(mask_in),
        .mode(mode),
        .in(in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out(out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_zero(out_zero),
        .count(count)
    );

    task automatic check(input string tag,
                         input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] op(input logic [1:0] m,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] k);
        case (m)
            2'b00:   return a & k;
            2'b01:   return a | k;
            2'b10:   return a ^ k;
            default: return a & ~k;
        endcase
    endfunction

    // One clock: check outputs against the model on the falling
    // edge, update the model, then move to just after the rise.
    task automatic step(output bit acc);
        logic [WIDTH-1:0] hd;
        int n;
        @(negedge clk);
        n = sb.size();
        hd = (n != 0) ? sb[0] : '0;
        check("in_ready", WIDTH'(in_ready), WIDTH'(n != DEPTH));
        check("out_valid", WIDTH'(out_valid), WIDTH'(n != 0));
        check("count", WIDTH'(count), WIDTH'(n));
        check("out", out, hd);
        check("out_zero", WIDTH'(out_zero), WIDTH'(n != 0 && hd == '0));
        acc = in_valid && (n != DEPTH);
        if (out_ready && n != 0) void'(sb.pop_front());
        if (acc) sb.push_back(op(mode, in, m_mask));
        if (mask_we) m_mask = mask_in;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        bit acc;
        in_valid = 1'b0;
        out_ready = ordy;
        repeat (n) begin
            step(acc);
            mask_we = 1'b0;
        end
    endtask

    task automatic offer(input logic [1:0] m,
                         input logic [WIDTH-1:0] d,
                         input logic ordy);
        bit acc;
        int tries;
        tries = 0;
        mode = m;
        in = d;
        in_valid = 1'b1;
        out_ready = ordy;
        do begin
            step(acc);
            mask_we = 1'b0;
            tries++;
        end while (!acc && tries < 20);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got=0 exp=1");
        end
        in_valid = 1'b0;
    endtask

    task automatic load_mask(input logic [WIDTH-1:0] k);
        mask_we = 1'b1;
        mask_in = k;
        idle(1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, WIDTH'(count), '0);
        check({tag, "_out_valid"}, WIDTH'(out_valid), '0);
        check({tag, "_out"}, out, '0);
        check({tag, "_out_zero"}, WIDTH'(out_zero), '0);
        check({tag, "_in_ready"}, WIDTH'(in_ready), WIDTH'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;

        #1;
        check_reset_outputs("rst0");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // mask load then AND with all ones
        load_mask(32'hf0f0f0f0);
        offer(2'b00, 32'hffffffff, 1'b1);
        check("s36_out", out, 32'hf0f0f0f0);
        check("s36_valid", WIDTH'(out_valid), WIDTH'(1));
        check("s36_zero", WIDTH'(out_zero), '0);
        idle(2, 1'b1);

        // mask write in the accept cycle uses the old mask
        load_mask(32'h50f37431);
        mask_we = 1'b1;
        mask_in = '0;
        offer(2'b00, 32'h12312312, 1'b1);
        check("s37_old", out, 32'h10312010);
        offer(2'b00, 32'h12312312, 1'b1);
        check("s37_new", out, 32'h00000000);
        check("s37_zero", WIDTH'(out_zero), WIDTH'(1));
        idle(2, 1'b1);

        // remaining modes
        load_mask(32'h50f37431);
        offer(2'b01, 32'h12312312, 1'b1);
        check("s38_or", out, 32'h52f37733);
        offer(2'b10, 32'h12312312, 1'b1);
        check("s38_xor", out, 32'h42c25723);
        offer(2'b11, 32'h12312312, 1'b1);
        check("s38_andn", out, 32'h02000302);
        idle(2, 1'b1);

        // backpressure: fill, hold C, drain
        offer(2'b01, 32'h0000000a, 1'b0);
        offer(2'b01, 32'h0000000b, 1'b0);
        check("s39_full_rdy", WIDTH'(in_ready), '0);
        mode = 2'b01;
        in = 32'h0000000c;
        in_valid = 1'b1;
        out_ready = 1'b0;
        repeat (3) step(acc);
        offer(2'b01, 32'h0000000c, 1'b1);
        idle(4, 1'b1);

        // simultaneous push and pop across pointer wrap
        offer(2'b10, 32'h00000100, 1'b0);
        for (int i = 0; i < 6; i++) begin
            offer(2'b10, 32'h00000200 + WIDTH'(i), 1'b1);
            check("s40_count", WIDTH'(count), WIDTH'(1));
        end
        idle(3, 1'b1);

        // asynchronous reset mid-cycle with a full buffer
        offer(2'b00, 32'h11111111, 1'b0);
        offer(2'b00, 32'h22222222, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("s41");
        sb.delete();
        m_mask = '1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        offer(2'b00, 32'h0000abcd, 1'b1);
        check("s41_mask", out, 32'h0000abcd);
        idle(2, 1'b1);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            mode = 2'($urandom_range(0, 3));
            in = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            mask_we = ($urandom_range(0, 7) == 0);
            mask_in = WIDTH'($urandom);
            step(acc);
        end
        mask_we = 1'b0;
        idle(4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
